// File: rtl/chip8_mem_loader.sv
// chip8_mem_loader: 4 KiB CHIP-8 RAM with hex-font init and UART program loader; LOAD_CHECKSUM_EN adds load_checksum
module chip8_mem_loader #(
    parameter int          CLK_HZ       = 27_000_000,
    parameter int          BAUD         = 115_200,
    parameter logic [11:0] LOAD_BASE    = 12'h200,
    parameter int          IDLE_TIMEOUT = CLK_HZ / 10
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [11:0] rd_memory_address,
    output logic [7:0]  rd_memory_data,
    input  logic [11:0] wr_memory_address,
    input  logic [7:0]  wr_memory_data,
    input  logic        wr_go,
    input  logic        uart_rx,
`ifdef LOAD_CHECKSUM_EN
    output logic [7:0]  load_checksum,
`endif
    output logic        load_active,
    output logic        load_done,
    output logic [11:0] load_count,
    output logic        load_error
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW = $clog2(CPB + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
    localparam logic [IW-1:0] IDLE_END = IW'(IDLE_TIMEOUT - 1);
    localparam logic [0:79][7:0] FONT = 640'hF0909090F0_2060202070_F010F080F0_F010F010F0_9090F01010_F080F010F0_F080F090F0_F010204040_F090F090F0_F090F010F0_F090F09090_E090E090E0_F0808080F0_E0909090E0_F080F080F0_F080F08080;

    typedef enum logic [1:0] {ST_FONT, ST_LOAD, ST_RUN} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    state_t        state, state_next;
    rx_state_t     rx_state, rx_next;
    logic [7:0]    mem [0:4095];
    logic          rx_meta, rx_s, rx_prev;
    logic [CW-1:0] rx_cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          rx_stb, stb_next, rx_ferr, ferr_next;
    logic [6:0]    font_idx;
    logic [IW-1:0] idle_cnt;
    logic          full, store, drop, we;
    logic [11:0]   load_addr, waddr;
    logic [7:0]    wdata;

    assign load_active = state != ST_RUN;
    assign load_done   = state == ST_RUN;
    assign load_addr   = LOAD_BASE + load_count;
    assign store       = state == ST_LOAD && rx_stb && !rx_ferr && !full;
    assign drop        = state == ST_LOAD && rx_stb && (rx_ferr || full);

    // UART receiver next state: half-bit start check, mid-bit data and stop sampling
    always_comb begin
        rx_next    = rx_state;
        cnt_next   = rx_cnt + CW'(1);
        bit_next   = bit_idx;
        shift_next = shift;
        stb_next   = 1'b0;
        ferr_next  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_s) rx_next = RX_START;
            end
            RX_START: if (rx_cnt == HALF_END) begin
                cnt_next = '0;
                bit_next = '0;
                rx_next  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == BIT_END) begin
                cnt_next   = '0;
                shift_next = {rx_s, shift[7:1]};
                bit_next   = bit_idx + 3'd1;
                if (bit_idx == 3'd7) rx_next = RX_STOP;
            end
            default: if (rx_cnt == BIT_END) begin
                cnt_next  = '0;
                rx_next   = RX_IDLE;
                stb_next  = 1'b1;
                ferr_next = !rx_s;
            end
        endcase
    end

    // UART synchroniser and receiver registers; line idles high out of reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_stb   <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_state <= rx_next;
            rx_cnt   <= cnt_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            rx_stb   <= stb_next;
            rx_ferr  <= ferr_next;
        end
    end

    // loader sequencing: font copy, then UART image until the line has been quiet long enough
    always_comb begin
        state_next = state;
        case (state)
            ST_FONT: state_next = font_idx == 7'd79 ? ST_LOAD : ST_FONT;
            ST_LOAD: state_next = (load_count != '0 && idle_cnt == IDLE_END) ? ST_RUN : ST_LOAD;
            default: state_next = ST_RUN;
        endcase
    end

    // single RAM write port: loader owns it until running, then the cpu
    always_comb begin
        we    = state == ST_FONT || store || (state == ST_RUN && wr_go);
        waddr = state == ST_FONT ? 12'h050 + {5'd0, font_idx} : state == ST_LOAD ? load_addr : wr_memory_address;
        wdata = state == ST_FONT ? FONT[font_idx] : state == ST_LOAD ? shift : wr_memory_data;
    end

    // loader state, byte counter, sticky error and idle-line timer; full blocks wrap past 0xFFF
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_FONT;
            font_idx   <= '0;
            load_count <= '0;
            load_error <= 1'b0;
            full       <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            state      <= state_next;
            font_idx   <= font_idx + 7'(state == ST_FONT);
            load_count <= load_count + 12'(store && load_count != 12'hFFF);
            load_error <= load_error | drop;
            full       <= full | (store && load_addr == 12'hFFF);
            idle_cnt   <= (rx_state != RX_IDLE || rx_stb) ? '0 : idle_cnt + IW'(idle_cnt != IDLE_END);
        end
    end

    // RAM array, never cleared so contents survive reset
    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read port; a same-cycle write shows up one cycle later
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) rd_memory_data <= '0;
        else rd_memory_data <= mem[rd_memory_address];
    end

`ifdef LOAD_CHECKSUM_EN
    // running mod-256 sum of stored bytes; only stores update it, so it freezes once running
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) load_checksum <= '0;
        else if (store) load_checksum <= load_checksum + shift;
    end
`endif
endmodule
